// File: rtl/reg_busy_decoder.sv
// Writeback address decoder with a per-register busy scoreboard.
// It handles issue gating, read-hazard flags and detection of writebacks to registers that are not busy.
module reg_busy_decoder #(
  parameter int ADDR_W      = 3,
  parameter int ZERO_REG_EN = 1,
  parameter int ZERO_REG    = 2**ADDR_W-1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_en,
  input  logic [ADDR_W-1:0]     issue_addr,
  output logic                  issue_ready,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  output logic [2**ADDR_W-1:0]  wr_sel,
  input  logic [ADDR_W-1:0]     rd_addr_a,
  input  logic [ADDR_W-1:0]     rd_addr_b,
  output logic                  hazard_a,
  output logic                  hazard_b,
  input  logic                  flush,
  output logic [2**ADDR_W-1:0]  busy_vec,
  output logic [ADDR_W:0]       busy_cnt,
  output logic                  wb_err
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam int CNT_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  function automatic logic exempt(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG_EN != 0) && (addr == ZERO_ADDR);
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

  logic                issue_acc;
  logic                wb_clr;
  logic                same_addr;
  logic                cnt_inc;
  logic                cnt_dec;
  logic                err_nxt;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [NUM_REGS-1:0] sel_nxt;

  // A retiring producer frees its slot in the same cycle, so that register can be reissued immediately.
  assign issue_ready = !busy_vec[issue_addr] || (wb_en && (wb_addr == issue_addr)) || exempt(issue_addr);
  assign issue_acc   = issue_en && issue_ready && !exempt(issue_addr);
  assign wb_clr      = wb_en && !exempt(wb_addr);
  assign same_addr   = issue_acc && wb_clr && (issue_addr == wb_addr);

  assign hazard_a = busy_vec[rd_addr_a] && !(wb_en && (wb_addr == rd_addr_a)) && !exempt(rd_addr_a);
  assign hazard_b = busy_vec[rd_addr_b] && !(wb_en && (wb_addr == rd_addr_b)) && !exempt(rd_addr_b);

  assign sel_nxt = wb_clr ? onehot(wb_addr) : '0;

  always_comb begin
    busy_nxt = busy_vec;
    cnt_inc  = 1'b0;
    cnt_dec  = 1'b0;
    err_nxt  = wb_err;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      // Clear before set so that an issue wins over a writeback to the same register.
      if (wb_clr)    busy_nxt[wb_addr]    = 1'b0;
      if (issue_acc) busy_nxt[issue_addr] = 1'b1;
      cnt_inc = issue_acc && !busy_vec[issue_addr];
      cnt_dec = wb_clr && busy_vec[wb_addr] && !same_addr;
      if (wb_clr && !busy_vec[wb_addr] && !same_addr) err_nxt = 1'b1;
    end
    cnt_nxt = flush ? '0 : busy_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  // Registered outputs: decoded write select and scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel   <= '0;
      busy_vec <= '0;
      busy_cnt <= '0;
      wb_err   <= 1'b0;
    end else begin
      wr_sel   <= sel_nxt;
      busy_vec <= busy_nxt;
      busy_cnt <= cnt_nxt;
      wb_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_reg_busy_decoder.sv
// Directed bench for reg_busy_decoder, covering the default 3-bit instance and a 5-bit instance.
module tb_reg_busy_decoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       issue_en, wb_en, flush, issue_ready, hazard_a, hazard_b, wb_err;
  logic [2:0] issue_addr, wb_addr, rd_addr_a, rd_addr_b;
  logic [7:0] wr_sel, busy_vec;
  logic [3:0] busy_cnt;

  reg_busy_decoder dut (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .issue_addr(issue_addr),
    .issue_ready(issue_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wr_sel(wr_sel),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .flush(flush), .busy_vec(busy_vec), .busy_cnt(busy_cnt), .wb_err(wb_err)
  );

  logic        w_issue_en, w_wb_en, w_issue_ready, w_hazard_a, w_hazard_b, w_wb_err;
  logic [4:0]  w_issue_addr, w_wb_addr, w_rd_addr_a;
  logic [31:0] w_wr_sel, w_busy_vec;
  logic [5:0]  w_busy_cnt;

  reg_busy_decoder #(.ADDR_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .issue_en(w_issue_en), .issue_addr(w_issue_addr),
    .issue_ready(w_issue_ready), .wb_en(w_wb_en), .wb_addr(w_wb_addr), .wr_sel(w_wr_sel),
    .rd_addr_a(w_rd_addr_a), .rd_addr_b(w_rd_addr_a), .hazard_a(w_hazard_a), .hazard_b(w_hazard_b),
    .flush(1'b0), .busy_vec(w_busy_vec), .busy_cnt(w_busy_cnt), .wb_err(w_wb_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    issue_en = 0; issue_addr = 0; wb_en = 0; wb_addr = 0;
    rd_addr_a = 0; rd_addr_b = 0; flush = 0;
    w_issue_en = 0; w_issue_addr = 0; w_wb_en = 0; w_wb_addr = 0; w_rd_addr_a = 0;
    cyc(); cyc();
    check("rst_busy_vec", busy_vec, 8'h00);
    check("rst_busy_cnt", busy_cnt, 4'd0);
    check("rst_wr_sel",   wr_sel,   8'h00);
    check("rst_wb_err",   wb_err,   1'b0);
    rst_n = 1'b1;

    // writeback to non-busy reg 3, then to the zero register
    wb_en = 1; wb_addr = 3;
    cyc();
    check("wb3_wr_sel", wr_sel, 8'b0000_1000);
    check("wb3_wb_err", wb_err, 1'b1);
    wb_addr = 7;
    cyc();
    check("wb7_wr_sel", wr_sel, 8'h00);
    check("wb7_wb_err", wb_err, 1'b1);
    wb_en = 0;

    // issue 2 then 5, then a blocked reissue of 5
    issue_en = 1; issue_addr = 2;
    cyc();
    issue_addr = 5; #1;
    check("iss5_ready", issue_ready, 1'b1);
    cyc();
    check("iss25_busy_vec", busy_vec, 8'b0010_0100);
    check("iss25_busy_cnt", busy_cnt, 4'd2);
    #1;
    check("reiss5_ready", issue_ready, 1'b0);
    cyc();
    check("reiss5_busy_cnt", busy_cnt, 4'd2);
    check("reiss5_busy_vec", busy_vec, 8'b0010_0100);

    // same-cycle issue and writeback of reg 5
    wb_en = 1; wb_addr = 5; #1;
    check("same5_ready", issue_ready, 1'b1);
    cyc();
    check("same5_busy_vec", busy_vec, 8'b0010_0100);
    check("same5_busy_cnt", busy_cnt, 4'd2);
    check("same5_wr_sel",   wr_sel,   8'b0010_0000);
    issue_en = 0; wb_en = 0;

    // hazards and bypass
    rd_addr_a = 2; rd_addr_b = 5; #1;
    check("haz_a_busy", hazard_a, 1'b1);
    check("haz_b_busy", hazard_b, 1'b1);
    wb_en = 1; wb_addr = 2; #1;
    check("haz_a_bypass", hazard_a, 1'b0);
    check("haz_b_other",  hazard_b, 1'b1);
    cyc();
    check("wb2_busy_vec", busy_vec, 8'b0010_0000);
    check("wb2_busy_cnt", busy_cnt, 4'd1);
    check("wb2_wr_sel",   wr_sel,   8'b0000_0100);
    wb_en = 0;

    // fill all non-exempt registers
    issue_en = 1;
    for (int i = 0; i < 7; i++) begin
      issue_addr = 3'(i);
      cyc();
    end
    check("fill_busy_vec", busy_vec, 8'h7F);
    check("fill_busy_cnt", busy_cnt, 4'd7);
    issue_addr = 7; rd_addr_a = 7; #1;
    check("iss7_ready", issue_ready, 1'b1);
    check("haz_zero",   hazard_a,    1'b0);
    cyc();
    check("iss7_busy_vec", busy_vec, 8'h7F);
    check("iss7_busy_cnt", busy_cnt, 4'd7);

    // flush takes priority over a simultaneous issue
    flush = 1; issue_addr = 1;
    cyc();
    check("flush_busy_vec", busy_vec, 8'h00);
    check("flush_busy_cnt", busy_cnt, 4'd0);
    flush = 0;

    // build up four busy registers, then apply reset asynchronously
    for (int i = 1; i < 5; i++) begin
      issue_addr = 3'(i);
      cyc();
    end
    issue_en = 0; wb_en = 1; wb_addr = 6;
    cyc();
    check("pre_rst_busy_cnt", busy_cnt, 4'd4);
    check("pre_rst_wr_sel",   wr_sel,   8'b0100_0000);
    wb_en = 0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy_vec", busy_vec, 8'h00);
    check("arst_busy_cnt", busy_cnt, 4'd0);
    check("arst_wr_sel",   wr_sel,   8'h00);
    check("arst_wb_err",   wb_err,   1'b0);
    cyc();
    rst_n = 1'b1;

    // 5-bit instance: reg 31 is exempt, wr_sel is 32 bits wide
    w_wb_en = 1; w_wb_addr = 31;
    cyc();
    check("w_wb31_wr_sel", w_wr_sel, 32'h0);
    check("w_wb31_wb_err", w_wb_err, 1'b0);
    w_wb_addr = 20;
    cyc();
    check("w_wb20_wr_sel", w_wr_sel, 32'h0010_0000);
    check("w_wb20_wb_err", w_wb_err, 1'b1);
    w_wb_en = 0; w_issue_en = 1; w_issue_addr = 31; #1;
    check("w_iss31_ready", w_issue_ready, 1'b1);
    cyc();
    check("w_iss31_busy_vec", w_busy_vec, 32'h0);
    w_issue_addr = 20;
    cyc();
    w_issue_en = 0; w_rd_addr_a = 20; #1;
    check("w_iss20_busy_vec", w_busy_vec, 32'h0010_0000);
    check("w_iss20_busy_cnt", w_busy_cnt, 6'd1);
    check("w_haz20",          w_hazard_a, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_busy_decoder.md
Name: reg_busy_decoder

Overview:
Parametrised N-to-2^N register-file write decoder with a per-register busy scoreboard for the pipelined CPU. It decodes the writeback address into a registered one-hot write-select vector for the register array. It tracks which registers have an in-flight producer and gates new issues and flags read hazards against that state. The zero register is never written and is never busy.

Parameters:
ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W (derived localparam, not overridable)
ZERO_REG_EN, 1, 1 = register ZERO_REG is hardwired zero (never selected, never busy)
ZERO_REG, 2**ADDR_W-1, index of the hardwired-zero register

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
issue_en  input  1  an instruction with a destination register requests issue
issue_addr  input  ADDR_W  destination register of issuing instruction
issue_ready  output  1  combinational; issue accepted this cycle when issue_en && issue_ready
wb_en  input  1  writeback valid
wb_addr  input  ADDR_W  writeback destination
wr_sel  output  NUM_REGS  registered one-hot write-select for register array
rd_addr_a  input  ADDR_W  read port A source register
rd_addr_b  input  ADDR_W  read port B source register
hazard_a  output  1  combinational; rd_addr_a has a pending producer
hazard_b  output  1  combinational; rd_addr_b has a pending producer
flush  input  1  synchronous clear of all busy state (pipeline flush)
busy_vec  output  NUM_REGS  registered busy bit per register
busy_cnt  output  ADDR_W+1  registered count of set busy bits
wb_err  output  1  sticky: writeback to a non-busy register observed

Behaviour:
- Reset (rst_n low, async): wr_sel=0, busy_vec=0, busy_cnt=0, wb_err=0. Outputs hold until first rising edge after rst_n deasserts.
- The zero register is "exempt" when ZERO_REG_EN=1 and the address equals ZERO_REG.
- wr_sel: one cycle latency.
  - Next value is the one-hot of wb_addr when wb_en=1 and the address is not exempt; otherwise all zeros.
  - At most one bit is set, always. flush does not affect wr_sel.
- issue_ready = !busy_vec[issue_addr] || (wb_en && wb_addr==issue_addr) || exempt(issue_addr).
  - The retiring producer's slot may be reissued in the same cycle.
- Busy update per edge, priority highest first:
  1. flush: all busy bits cleared; issue and wb ignored this cycle; busy_cnt=0.
  2. Accepted issue to a non-exempt register: sets busy[issue_addr].
  3. wb_en to a non-exempt register: clears busy[wb_addr].
- Same address for accepted issue and wb in one cycle: bit stays 1 (set wins); busy_cnt unchanged.
- Different addresses: both applied; busy_cnt unchanged.
- issue_en with issue_ready=0: no state change. Issue to an exempt address: accepted, no state change.
- wb_en to a non-busy, non-exempt register (not simultaneously issued): wb_err set and sticky until reset. Busy unchanged; wr_sel still generated.
- busy_cnt tracks popcount(busy_vec) incrementally (+1 / -1 / 0) and never wraps. Maximum is NUM_REGS-1 when ZERO_REG_EN=1, NUM_REGS otherwise.
- hazard_x = busy_vec[rd_addr_x] && !(wb_en && wb_addr==rd_addr_x). A same-cycle writeback is bypassed and not reported as a hazard. Exempt addresses always give 0.
- Async reset mid-operation discards all busy state immediately; no partial-update glitches are observable after the reset edge.

Test Plan:
- Reset then wb_en=1, wb_addr=3 -> next cycle wr_sel=8'b0000_1000, wb_err=1 (reg 3 was not busy); wb_addr=7 (zero reg) -> wr_sel=0, wb_err unchanged.
- issue 2, 5 on consecutive cycles -> busy_vec=8'b0010_0100, busy_cnt=2; issue 5 again -> issue_ready=0, busy_cnt stays 2.
- With reg 5 busy: issue_en=1, issue_addr=5, wb_en=1, wb_addr=5 same cycle -> issue_ready=1, busy[5] stays 1, busy_cnt stays 2, wr_sel bit5 next cycle.
- With reg 2 busy: rd_addr_a=2, no wb -> hazard_a=1; add wb_addr=2 same cycle -> hazard_a=0, next cycle busy[2]=0, busy_cnt decrements.
- Issue 0..6 (7 regs) -> busy_cnt=7, issue 7 accepted with no change; then flush together with issue 1 -> busy_vec=0, busy_cnt=0.
- Drop rst_n mid-sequence with busy_cnt=4 -> busy_vec, busy_cnt, wr_sel, wb_err all 0 without waiting for a clk edge; ADDR_W=5 rerun -> reg 31 exempt, wr_sel 32 bits one-hot.
